// File: rtl/mdio_pkg.sv
// Shared constants, FSM encoding and power-on register defaults
// for the clause-22 MDIO PHY management emulator.
package mdio_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam logic [4:0] BIT_ST1  = 5'd1;
    localparam logic [4:0] BIT_OP   = 5'd3;
    localparam logic [4:0] BIT_PHY  = 5'd8;
    localparam logic [4:0] BIT_REG  = 5'd13;
    localparam logic [4:0] BIT_TA0  = 5'd14;
    localparam logic [4:0] BIT_TA1  = 5'd15;
    localparam logic [4:0] BIT_LAST = 5'd31;

    localparam logic [5:0] PRE_SAT = 6'd32;

    typedef enum logic [3:0] {
        PRE,
        ST1,
        OP,
        PHYAD,
        REGAD,
        TA,
        WDATA,
        RDATA,
        SKIP
    } state_e;

    function automatic logic [15:0] reg_default(input logic [4:0] a);
        logic [15:0] v;
        case (a)
            5'd0:    v = 16'h1140;
            5'd1:    v = 16'h7949;
            5'd2:    v = 16'h0141;
            5'd3:    v = 16'h0CC2;
            5'd4:    v = 16'h01E1;
            5'd7:    v = 16'h2001;
            5'd9:    v = 16'h0F00;
            5'd10:   v = 16'h4000;
            5'd15:   v = 16'h3000;
            5'd16:   v = 16'h0308;
            5'd17:   v = 16'h8110;
            5'd19:   v = 16'h0010;
            5'd20:   v = 16'h0C60;
            5'd24:   v = 16'h4100;
            5'd26:   v = 16'h000A;
            5'd27:   v = 16'h848B;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mdio_regfile.sv
// 32x16 PHY register file: reset to defaults, masked synchronous
// write, combinational read.
module mdio_regfile
    import mdio_pkg::*;
#(
    parameter logic [31:0] RO_MASK = 32'h0000_000E
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [4:0]  i_raddr,
    output logic [15:0] o_rdata
);

    logic [15:0] r_mem [32];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= reg_default(5'(i));
            end
        end else if (i_we && !RO_MASK[i_waddr]) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mdio_phy_emulator.sv
// Clause-22 MDIO management slave: decodes frames bit by bit on
// i_clk, commits writes to the register file and serves reads.
module mdio_phy_emulator
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter int          PREAMBLE_MIN = 32,
    parameter logic [31:0] RO_MASK      = 32'h0000_000E
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mdio,
    output logic        o_mdio,
    output logic        o_mdio_oe,
    output logic        o_wr_strobe,
    output logic        o_rd_strobe,
    output logic [4:0]  o_reg_addr,
    output logic [15:0] o_reg_data,
    output logic        o_err,
    output logic        o_all_written
);

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

    state_e      r_state;
    logic [5:0]  r_pre_cnt;
    logic [4:0]  r_bit;
    logic        r_op_hi;
    logic        r_is_read;
    logic [4:0]  r_phy;
    logic [4:0]  r_regad;
    logic [15:0] r_wdata;
    logic [15:0] r_snap;
    logic [15:0] r_shift;
    logic [31:0] r_written;

    logic [1:0]  w_op;
    logic [4:0]  w_phy_next;
    logic [4:0]  w_regad_next;
    logic [15:0] w_wdata_next;
    logic        w_commit;
    logic        w_ro;
    logic        w_we;
    logic [31:0] w_written_next;
    logic [15:0] w_rdata;

    assign w_op           = {r_op_hi, i_mdio};
    assign w_phy_next     = {r_phy[3:0], i_mdio};
    assign w_regad_next   = {r_regad[3:0], i_mdio};
    assign w_wdata_next   = {r_wdata[14:0], i_mdio};
    assign w_commit       = (r_state == WDATA) && (r_bit == BIT_LAST);
    assign w_ro           = RO_MASK[r_regad];
    assign w_we           = w_commit && !w_ro;
    assign w_written_next = r_written | (32'(w_we) << r_regad);

    // Read address follows the REGAD shifter so the snapshot at the
    // last REGAD bit sees the complete address.
    mdio_regfile #(
        .RO_MASK (RO_MASK)
    ) u_regfile (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (w_we),
        .i_waddr (r_regad),
        .i_wdata (w_wdata_next),
        .i_raddr (w_regad_next),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= PRE;
            r_pre_cnt     <= 6'd0;
            r_bit         <= 5'd0;
            r_op_hi       <= 1'b0;
            r_is_read     <= 1'b0;
            r_phy         <= 5'd0;
            r_regad       <= 5'd0;
            r_wdata       <= 16'd0;
            r_snap        <= 16'd0;
            r_shift       <= 16'd0;
            r_written     <= 32'd0;
            o_mdio        <= 1'b1;
            o_mdio_oe     <= 1'b0;
            o_wr_strobe   <= 1'b0;
            o_rd_strobe   <= 1'b0;
            o_reg_addr    <= 5'd0;
            o_reg_data    <= 16'd0;
            o_err         <= 1'b0;
            o_all_written <= 1'b0;
        end else begin
            o_wr_strobe <= 1'b0;
            o_rd_strobe <= 1'b0;
            o_err       <= 1'b0;
            r_bit       <= r_bit + 5'd1;
            unique case (r_state)
                PRE: begin
                    r_bit <= BIT_ST1;
                    if (i_mdio) begin
                        if (r_pre_cnt != PRE_SAT) begin
                            r_pre_cnt <= r_pre_cnt + 6'd1;
                        end
                    end else if (r_pre_cnt >= PRE_MIN) begin
                        r_state   <= ST1;
                        r_pre_cnt <= 6'd0;
                    end else begin
                        r_pre_cnt <= 6'd0;
                    end
                end
                ST1: begin
                    if (i_mdio) begin
                        r_state <= OP;
                    end else begin
                        r_state <= PRE;
                        o_err   <= 1'b1;
                    end
                end
                OP: begin
                    if (r_bit != BIT_OP) begin
                        r_op_hi <= i_mdio;
                    end else if (w_op == OP_WRITE || w_op == OP_READ) begin
                        r_is_read <= (w_op == OP_READ);
                        r_state   <= PHYAD;
                    end else begin
                        r_state <= PRE;
                        o_err   <= 1'b1;
                    end
                end
                PHYAD: begin
                    r_phy <= w_phy_next;
                    if (r_bit == BIT_PHY) begin
                        r_state <= (w_phy_next == PHY_ADDR) ? REGAD : SKIP;
                    end
                end
                REGAD: begin
                    r_regad <= w_regad_next;
                    if (r_bit == BIT_REG) begin
                        r_snap  <= w_rdata;
                        r_state <= TA;
                    end
                end
                TA: begin
                    if (r_is_read) begin
                        o_mdio_oe <= 1'b1;
                        if (r_bit == BIT_TA0) begin
                            o_mdio <= 1'b0;
                        end else begin
                            o_mdio  <= r_snap[15];
                            r_shift <= {r_snap[14:0], 1'b0};
                            r_state <= RDATA;
                        end
                    end else if (r_bit == BIT_TA0) begin
                        if (!i_mdio) begin
                            r_state <= PRE;
                            o_err   <= 1'b1;
                        end
                    end else if (i_mdio) begin
                        r_state <= PRE;
                        o_err   <= 1'b1;
                    end else begin
                        r_state <= WDATA;
                    end
                end
                WDATA: begin
                    r_wdata <= w_wdata_next;
                    if (w_commit) begin
                        r_state <= PRE;
                        if (w_ro) begin
                            o_err <= 1'b1;
                        end else begin
                            o_wr_strobe   <= 1'b1;
                            o_reg_addr    <= r_regad;
                            o_reg_data    <= w_wdata_next;
                            r_written     <= w_written_next;
                            o_all_written <= o_all_written |
                                ((w_written_next & ~RO_MASK) == ~RO_MASK);
                        end
                    end
                end
                RDATA: begin
                    if (r_bit == BIT_LAST) begin
                        r_state     <= PRE;
                        o_mdio_oe   <= 1'b0;
                        o_mdio      <= 1'b1;
                        o_rd_strobe <= 1'b1;
                        o_reg_addr  <= r_regad;
                        o_reg_data  <= r_snap;
                    end else begin
                        o_mdio  <= r_shift[15];
                        r_shift <= {r_shift[14:0], 1'b0};
                    end
                end
                SKIP: begin
                    if (r_bit == BIT_LAST) begin
                        r_state <= PRE;
                    end
                end
                default: begin
                    r_state   <= PRE;
                    o_mdio_oe <= 1'b0;
                    o_mdio    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_phy_emulator.sv
// Scoreboard bench: frame tasks queue expected strobes, a negedge
// monitor pops and compares them against both emulator instances.
module tb_mdio_phy_emulator;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_RD   = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;
    localparam logic [1:0] W      = 2'b01;
    localparam logic [1:0] R      = 2'b10;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic drv = 1'b0;
    logic sel0 = 1'b0;

    logic        line_a, oe_a, mo_a, wr_a, rd_a, er_a, aw_a;
    logic [4:0]  ra_a;
    logic [15:0] rd_data_a;
    logic        line_b, oe_b, mo_b, wr_b, rd_b, er_b, aw_b;
    logic [4:0]  ra_b;
    logic [15:0] rd_data_b;

    assign line_a = oe_a ? mo_a : drv;
    assign line_b = oe_b ? mo_b : (sel0 ? drv : 1'b1);

    mdio_phy_emulator dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_mdio        (line_a),
        .o_mdio        (mo_a),
        .o_mdio_oe     (oe_a),
        .o_wr_strobe   (wr_a),
        .o_rd_strobe   (rd_a),
        .o_reg_addr    (ra_a),
        .o_reg_data    (rd_data_a),
        .o_err         (er_a),
        .o_all_written (aw_a)
    );

    mdio_phy_emulator #(
        .PREAMBLE_MIN (0)
    ) dut0 (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_mdio        (line_b),
        .o_mdio        (mo_b),
        .o_mdio_oe     (oe_b),
        .o_wr_strobe   (wr_b),
        .o_rd_strobe   (rd_b),
        .o_reg_addr    (ra_b),
        .o_reg_data    (rd_data_b),
        .o_err         (er_b),
        .o_all_written (aw_b)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    ev_t q0[$];
    ev_t q1[$];
    logic [16:0] cap [2];
    int cnt [2];
    logic prev [2];
    int oe_tot [2];
    int exp_oe [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    task automatic push(input int dev, input logic [1:0] k,
                        input logic [4:0] a, input logic [15:0] d,
                        input int c);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        if (dev == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic oe, input logic mo,
                       input logic wr, input logic rd, input logic er,
                       input logic [4:0] a, input logic [15:0] dat);
        ev_t e;
        logic [1:0] k;
        int nk;
        int qs;
        if (oe) begin
            if (!prev[d]) begin
                cap[d] = '0;
                cnt[d] = 0;
            end
            cap[d] = {cap[d][15:0], mo};
            cnt[d]++;
            oe_tot[d]++;
        end
        prev[d] = oe;
        nk = int'(wr) + int'(rd) + int'(er);
        if (nk == 0) return;
        k = wr ? K_WR : (rd ? K_RD : K_ERR);
        qs = (d == 0) ? q0.size() : q1.size();
        if (nk > 1 || qs == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL dev%0d unexpected event: wr=%b rd=%b err=%b, required none",
                     d, wr, rd, er);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        check($sformatf("dev%0d event kind", d), 32'(k), 32'(e.kind));
        check($sformatf("dev%0d event cycle", d), cyc, e.cyc);
        if (k != K_ERR) begin
            check($sformatf("dev%0d reg_addr", d), 32'(a), 32'(e.addr));
            check($sformatf("dev%0d reg_data", d), 32'(dat), 32'(e.data));
        end
        if (k == K_RD) begin
            check($sformatf("dev%0d oe cycles reg%0d", d, e.addr), cnt[d], 17);
            check($sformatf("dev%0d serial reg%0d", d, e.addr),
                  32'(cap[d]), {15'd0, 1'b0, e.data});
        end
    endtask

    always @(negedge clk) begin
        mon(0, oe_a, mo_a, wr_a, rd_a, er_a, ra_a, rd_data_a);
        mon(1, oe_b, mo_b, wr_b, rd_b, er_b, ra_b, rd_data_b);
    end

    // One clause-22 frame; read frames release the line from bit 14.
    task automatic frame(input int dev, input int npre, input logic [1:0] op,
                         input logic [4:0] phy, input logic [4:0] ra,
                         input logic [1:0] ta, input logic [15:0] d,
                         input logic [1:0] ek, input logic [15:0] ed,
                         input int ebit, input int rbit);
        logic [31:0] f;
        f = {2'b01, op, phy, ra, ta, d};
        if (op == R) f[17:0] = '1;
        for (int i = 0; i < npre; i++) begin
            @(negedge clk);
            sel0 = (dev == 1);
            drv  = 1'b1;
        end
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            sel0 = (dev == 1);
            if (rbit > 0 && n == rbit + 1) begin
                check("reset mid-read oe", 32'(oe_a), 32'd0);
                rst = 1'b0;
            end
            if (rbit > 0 && n == rbit) rst = 1'b1;
            drv = f[31-n];
            if (ek != K_NONE && n == ebit) push(dev, ek, ra, ed, cyc + 1);
        end
        if (ek == K_RD) exp_oe[dev] += 17;
        @(negedge clk);
        sel0 = 1'b0;
        drv  = 1'b0;
    endtask

    function automatic logic [15:0] val(input int r);
        return 16'h5A00 ^ 16'(r * 16'h0111);
    endfunction

    function automatic logic [15:0] ro_def(input int r);
        logic [15:0] v;
        case (r)
            1:       v = 16'h7949;
            2:       v = 16'h0141;
            default: v = 16'h0CC2;
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            cap[d] = '0;
            cnt[d] = 0;
            prev[d] = 1'b0;
            oe_tot[d] = 0;
            exp_oe[d] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset oe", 32'(oe_a), 32'd0);
        check("reset mdio", 32'(mo_a), 32'd1);
        check("reset all_written", 32'(aw_a), 32'd0);
        check("reset reg_addr", 32'(ra_a), 32'd0);
        check("reset reg_data", 32'(rd_data_a), 32'd0);
        check("reset err", 32'(er_a), 32'd0);

        frame(0, 32, W, 5'd0, 5'd0, 2'b10, 16'h1140, K_WR, 16'h1140, 31, 0);
        frame(0, 32, R, 5'd0, 5'd0, 2'b10, 16'h0000, K_RD, 16'h1140, 31, 0);

        frame(0, 32, W, 5'd0, 5'd1, 2'b10, 16'hFFFF, K_ERR, 16'h0, 31, 0);
        frame(0, 32, R, 5'd0, 5'd1, 2'b10, 16'h0000, K_RD, 16'h7949, 31, 0);

        frame(0, 32, W, 5'd1, 5'd4, 2'b10, 16'h1234, K_NONE, 16'h0, 0, 0);
        frame(0, 32, R, 5'd1, 5'd0, 2'b10, 16'h0000, K_NONE, 16'h0, 0, 0);
        frame(0, 32, W, 5'd0, 5'd4, 2'b10, 16'hBEEF, K_WR, 16'hBEEF, 31, 0);
        frame(0, 32, R, 5'd0, 5'd4, 2'b10, 16'h0000, K_RD, 16'hBEEF, 31, 0);

        frame(0, 31, W, 5'd0, 5'd5, 2'b10, 16'h5555, K_NONE, 16'h0, 0, 0);
        frame(0, 32, R, 5'd0, 5'd5, 2'b10, 16'h0000, K_RD, 16'h0000, 31, 0);
        frame(1, 0, W, 5'd0, 5'd5, 2'b10, 16'h5555, K_WR, 16'h5555, 31, 0);
        frame(1, 0, R, 5'd0, 5'd5, 2'b10, 16'h0000, K_RD, 16'h5555, 31, 0);

        frame(0, 32, W, 5'd0, 5'd0, 2'b11, 16'hDEAD, K_ERR, 16'h0, 15, 0);
        frame(0, 32, R, 5'd0, 5'd0, 2'b10, 16'h0000, K_RD, 16'h1140, 31, 0);
        frame(0, 32, 2'b11, 5'd0, 5'd0, 2'b10, 16'h0000, K_ERR, 16'h0, 3, 0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) begin
            if (r >= 1 && r <= 3) continue;
            frame(0, 32, W, 5'd0, 5'(r), 2'b10, val(r), K_WR, val(r), 31, 0);
            if (r == 30) check("all_written after 28 writes", 32'(aw_a), 32'd0);
            if (r == 31) check("all_written after 29 writes", 32'(aw_a), 32'd1);
        end
        for (int r = 0; r < 32; r++) begin
            frame(0, 32, R, 5'd0, 5'(r), 2'b10, 16'h0, K_RD,
                  (r >= 1 && r <= 3) ? ro_def(r) : val(r), 31, 0);
        end

        frame(0, 32, R, 5'd0, 5'd4, 2'b10, 16'h0000, K_NONE, 16'h0, 0, 20);
        exp_oe[0] += 6;
        check("all_written after reset", 32'(aw_a), 32'd0);
        frame(0, 32, R, 5'd0, 5'd4, 2'b10, 16'h0000, K_RD, 16'h01E1, 31, 0);
        frame(0, 32, R, 5'd0, 5'd0, 2'b10, 16'h0000, K_RD, 16'h1140, 31, 0);

        repeat (4) @(negedge clk);
        check("dev0 pending events", q0.size(), 0);
        check("dev1 pending events", q1.size(), 0);
        check("dev0 total oe cycles", oe_tot[0], exp_oe[0]);
        check("dev1 total oe cycles", oe_tot[1], exp_oe[1]);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
